// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - command sequencer with an 8x16 register file in front of a 16-bit ALU
// Accepts one command at a time, drives the ALU in EXEC, captures and writes back, then responds.
module alu_seq #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_op,
   input  logic [REG_AW-1:0] cmd_dst,
   input  logic [REG_AW-1:0] cmd_srca,
   input  logic [REG_AW-1:0] cmd_srcb,
   input  logic [DATA_W-1:0] cmd_imm,

   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic [3:0]        op,
   input  logic [DATA_W-1:0] result,
   input  logic              carry,
   input  logic              zero,

   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_carry,
   output logic              rsp_zero,

   output logic              flag_c,
   output logic              flag_z
);

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_EXEC = 2'b01;
   localparam logic [1:0] S_RESP = 2'b10;

   localparam logic [3:0] OP_READ  = 4'b1110;
   localparam logic [3:0] OP_LOADI = 4'b1111;

   logic [1:0]        state;
   logic [1:0]        state_nxt;

   logic [3:0]        op_q;
   logic [REG_AW-1:0] dst_q;
   logic [REG_AW-1:0] srca_q;
   logic [REG_AW-1:0] srcb_q;
   logic [DATA_W-1:0] imm_q;

   logic [DATA_W-1:0] rf [NREG];

   logic              cmd_fire;
   logic              rsp_fire;
   logic              in_exec;
   logic              is_alu;
   logic              is_read;
   logic              is_loadi;
   logic [DATA_W-1:0] rd_a;
   logic [DATA_W-1:0] rd_b;
   logic [DATA_W-1:0] wr_data;

   assign cmd_ready = (state == S_IDLE);
   assign rsp_valid = (state == S_RESP);
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign rsp_fire  = rsp_valid && rsp_ready;
   assign in_exec   = (state == S_EXEC);

   assign is_read  = (op_q == OP_READ);
   assign is_loadi = (op_q == OP_LOADI);
   assign is_alu   = !is_read && !is_loadi;

   // Sources are read combinationally, so a DST that aliases a source still sees the old value.
   assign rd_a    = rf[srca_q];
   assign rd_b    = rf[srcb_q];
   assign wr_data = is_loadi ? imm_q : result;

   always_comb begin
      a  = '0;
      b  = '0;
      op = 4'b0000;
      if (in_exec && is_alu) begin
         a  = rd_a;
         b  = rd_b;
         op = op_q;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (cmd_fire) state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_RESP;
         S_RESP:  if (rsp_fire) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= 4'b0000;
         dst_q  <= '0;
         srca_q <= '0;
         srcb_q <= '0;
         imm_q  <= '0;
      end else if (cmd_fire) begin
         op_q   <= cmd_op;
         dst_q  <= cmd_dst;
         srca_q <= cmd_srca;
         srcb_q <= cmd_srcb;
         imm_q  <= cmd_imm;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            rf[i] <= '0;
         end
      end else if (in_exec && !is_read) begin
         rf[dst_q] <= wr_data;
      end
   end

   // Response fields and architectural flags are captured once, at the end of EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data  <= '0;
         rsp_carry <= 1'b0;
         rsp_zero  <= 1'b0;
         flag_c    <= 1'b0;
         flag_z    <= 1'b0;
      end else if (in_exec) begin
         if (is_loadi) begin
            rsp_data  <= imm_q;
            rsp_carry <= 1'b0;
            rsp_zero  <= (imm_q == '0);
         end else if (is_read) begin
            rsp_data  <= rd_a;
            rsp_carry <= 1'b0;
            rsp_zero  <= (rd_a == '0);
         end else begin
            rsp_data  <= result;
            rsp_carry <= carry;
            rsp_zero  <= zero;
            flag_c    <= carry;
            flag_z    <= zero;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with a behavioural ALU and register-file model
module tb_alu_seq;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [2:0]  cmd_dst;
   logic [2:0]  cmd_srca;
   logic [2:0]  cmd_srcb;
   logic [15:0] cmd_imm;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [3:0]  alu_op;
   logic [15:0] alu_result;
   logic        alu_carry;
   logic        alu_zero;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_carry;
   logic        rsp_zero;
   logic        flag_c;
   logic        flag_z;

   int checks;
   int errors;

   logic [15:0] m_rf [8];
   logic        m_fc;
   logic        m_fz;

   localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, XOR = 4'd4, SHL = 4'd5;
   localparam logic [3:0] RD = 4'hE, LDI = 4'hF;

   alu_seq #(.DATA_W(16), .NREG(8), .REG_AW(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_dst   (cmd_dst),
      .cmd_srca  (cmd_srca),
      .cmd_srcb  (cmd_srcb),
      .cmd_imm   (cmd_imm),
      .a         (alu_a),
      .b         (alu_b),
      .op        (alu_op),
      .result    (alu_result),
      .carry     (alu_carry),
      .zero      (alu_zero),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_carry (rsp_carry),
      .rsp_zero  (rsp_zero),
      .flag_c    (flag_c),
      .flag_z    (flag_z)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: SUB carry means no borrow; opcodes 7..13 are unimplemented and return 0.
   function automatic logic [16:0] alu_ref(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
      logic [16:0] s;
      case (o)
         4'd0:    s = {1'b0, x} + {1'b0, y};
         4'd1:    s = {(x >= y), 16'(x - y)};
         4'd2:    s = {1'b0, x & y};
         4'd3:    s = {1'b0, x | y};
         4'd4:    s = {1'b0, x ^ y};
         4'd5:    s = {x[15], 16'(x << 1)};
         4'd6:    s = {x[0], 16'(x >> 1)};
         default: s = 17'd0;
      endcase
      return s;
   endfunction

   assign {alu_carry, alu_result} = alu_ref(alu_op, alu_a, alu_b);
   assign alu_zero = (alu_result == 16'd0);

   task automatic model_cmd(input logic [3:0] o, input logic [2:0] d, input logic [2:0] sa,
                            input logic [2:0] sb, input logic [15:0] imm,
                            output logic [15:0] ed, output logic ec, output logic ez,
                            output logic [15:0] ea, output logic [15:0] eb, output logic [3:0] eop);
      logic [16:0] r;
      ea = 16'd0; eb = 16'd0; eop = 4'd0;
      if (o == LDI) begin
         ed = imm; ec = 1'b0; ez = (imm == 16'd0);
         m_rf[d] = imm;
      end else if (o == RD) begin
         ed = m_rf[sa]; ec = 1'b0; ez = (ed == 16'd0);
      end else begin
         ea = m_rf[sa]; eb = m_rf[sb]; eop = o;
         r = alu_ref(o, ea, eb);
         ed = r[15:0]; ec = r[16]; ez = (ed == 16'd0);
         m_rf[d] = ed; m_fc = ec; m_fz = ez;
      end
   endtask

   task automatic issue(input logic [3:0] o, input logic [2:0] d, input logic [2:0] sa,
                        input logic [2:0] sb, input logic [15:0] imm,
                        output logic [15:0] rd, output logic rc, output logic rz, output int lat,
                        output logic [15:0] xa, output logic [15:0] xb, output logic [3:0] xop);
      int n;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      cmd_op = o; cmd_dst = d; cmd_srca = sa; cmd_srcb = sb; cmd_imm = imm;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      xa = alu_a; xb = alu_b; xop = alu_op;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = rsp_data; rc = rsp_carry; rz = rsp_zero;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) m_rf[i] = 16'd0;
      m_fc = 1'b0;
      m_fz = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] d, xa, xb;
      logic c, z;
      logic [3:0] xo;
      int lat;
      cmd_op = LDI; cmd_dst = 3'd1; cmd_imm = 16'h5A5A; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      cmd_op = LDI; cmd_dst = 3'd0; cmd_imm = 16'h1234; cmd_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
      checks++; if ({rsp_data, rsp_carry, rsp_zero} !== 18'd0) begin errors++; $display("FAIL reset_rsp_fields: got %h/%0b/%0b want 0", rsp_data, rsp_carry, rsp_zero); end
      checks++; if ({flag_c, flag_z} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %0b%0b want 00", flag_c, flag_z); end
      checks++; if ({alu_a, alu_b, alu_op} !== 36'd0) begin errors++; $display("FAIL reset_alu_drive: got %h %h %h want 0", alu_a, alu_b, alu_op); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      rst_n = 1'b1;
      for (int r = 0; r < 8; r++) begin
         issue(RD, 3'd0, 3'(r), 3'd0, 16'd0, d, c, z, lat, xa, xb, xo);
         checks++; if (d !== 16'h0000 || z !== 1'b1) begin errors++; $display("FAIL reset_read_r%0d: got %h zero=%0b want 0000 zero=1", r, d, z); end
      end
   endtask

   task automatic test_add_carry();
      logic [15:0] d, xa, xb;
      logic c, z;
      logic [3:0] xo;
      int lat;
      issue(LDI, 3'd1, 3'd0, 3'd0, 16'hFFFF, d, c, z, lat, xa, xb, xo);
      checks++; if (d !== 16'hFFFF || c !== 1'b0 || z !== 1'b0) begin errors++; $display("FAIL loadi_ffff: got %h/%0b/%0b want ffff/0/0", d, c, z); end
      issue(LDI, 3'd2, 3'd0, 3'd0, 16'h0001, d, c, z, lat, xa, xb, xo);
      issue(ADD, 3'd3, 3'd1, 3'd2, 16'd0, d, c, z, lat, xa, xb, xo);
      checks++; if (d !== 16'h0000 || c !== 1'b1 || z !== 1'b1) begin errors++; $display("FAIL add_carry_rsp: got %h/%0b/%0b want 0000/1/1", d, c, z); end
      checks++; if (flag_c !== 1'b1 || flag_z !== 1'b1) begin errors++; $display("FAIL add_carry_flags: got %0b%0b want 11", flag_c, flag_z); end
      issue(RD, 3'd0, 3'd3, 3'd0, 16'd0, d, c, z, lat, xa, xb, xo);
      checks++; if (d !== 16'h0000 || z !== 1'b1) begin errors++; $display("FAIL read_r3: got %h zero=%0b want 0000 zero=1", d, z); end
      checks++; if (flag_c !== 1'b1 || flag_z !== 1'b1) begin errors++; $display("FAIL read_keeps_flags: got %0b%0b want 11", flag_c, flag_z); end
      checks++; if (xa !== 16'd0 || xo !== 4'd0) begin errors++; $display("FAIL read_no_alu_drive: got a=%h op=%h want 0", xa, xo); end
   endtask

   task automatic test_sub_xor();
      logic [15:0] d, xa, xb;
      logic c, z;
      logic [3:0] xo;
      int lat;
      issue(SUB, 3'd4, 3'd2, 3'd1, 16'd0, d, c, z, lat, xa, xb, xo);
      checks++; if (d !== 16'h0002 || c !== 1'b0 || z !== 1'b0) begin errors++; $display("FAIL sub_rsp: got %h/%0b/%0b want 0002/0/0", d, c, z); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL sub_latency: got %0d want 2", lat); end
      issue(XOR, 3'd5, 3'd1, 3'd1, 16'd0, d, c, z, lat, xa, xb, xo);
      checks++; if (d !== 16'h0000 || z !== 1'b1) begin errors++; $display("FAIL xor_rsp: got %h zero=%0b want 0000 zero=1", d, z); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL xor_latency: got %0d want 2", lat); end
   endtask

   task automatic test_shift_in_place();
      logic [15:0] d, xa, xb;
      logic c, z;
      logic [3:0] xo;
      int lat;
      issue(LDI, 3'd1, 3'd0, 3'd0, 16'h8001, d, c, z, lat, xa, xb, xo);
      issue(SHL, 3'd1, 3'd1, 3'd0, 16'd0, d, c, z, lat, xa, xb, xo);
      checks++; if (d !== 16'h0002) begin errors++; $display("FAIL shl_rsp: got %h want 0002", d); end
      checks++; if (xa !== 16'h8001 || xo !== 4'b0101) begin errors++; $display("FAIL shl_exec_drive: got a=%h op=%b want 8001 0101", xa, xo); end
      issue(RD, 3'd0, 3'd1, 3'd0, 16'd0, d, c, z, lat, xa, xb, xo);
      checks++; if (d !== 16'h0002) begin errors++; $display("FAIL shl_writeback: got %h want 0002", d); end
   endtask

   task automatic test_idle_hold();
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 16'h0002 || alu_op !== 4'd0) begin
            errors++;
            $display("FAIL idle_hold: got ready=%0b valid=%0b data=%h op=%h want 1 0 0002 0", cmd_ready, rsp_valid, rsp_data, alu_op);
         end
      end
   endtask

   task automatic test_unimplemented_op();
      logic [15:0] d, xa, xb;
      logic c, z;
      logic [3:0] xo;
      int lat;
      issue(LDI, 3'd2, 3'd0, 3'd0, 16'h1234, d, c, z, lat, xa, xb, xo);
      issue(4'b1101, 3'd2, 3'd2, 3'd2, 16'd0, d, c, z, lat, xa, xb, xo);
      checks++; if (d !== 16'h0000 || c !== 1'b0 || z !== 1'b1) begin errors++; $display("FAIL unimpl_rsp: got %h/%0b/%0b want 0000/0/1", d, c, z); end
      checks++; if (xo !== 4'b1101 || xa !== 16'h1234) begin errors++; $display("FAIL unimpl_forward: got op=%b a=%h want 1101 1234", xo, xa); end
      checks++; if (flag_c !== 1'b0 || flag_z !== 1'b1) begin errors++; $display("FAIL unimpl_flags: got %0b%0b want 01", flag_c, flag_z); end
      issue(RD, 3'd0, 3'd2, 3'd0, 16'd0, d, c, z, lat, xa, xb, xo);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL unimpl_writeback: got %h want 0000", d); end
   endtask

   task automatic test_backpressure();
      logic [15:0] d, xa, xb;
      logic c, z;
      logic [3:0] xo;
      int lat;
      issue(LDI, 3'd1, 3'd0, 3'd0, 16'h1111, d, c, z, lat, xa, xb, xo);
      issue(LDI, 3'd2, 3'd0, 3'd0, 16'h2222, d, c, z, lat, xa, xb, xo);
      cmd_op = ADD; cmd_dst = 3'd3; cmd_srca = 3'd1; cmd_srcb = 3'd2; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      cmd_op = LDI; cmd_dst = 3'd7; cmd_imm = 16'h0777; cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data !== 16'h3333 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold_%0d: got valid=%0b data=%h ready=%0b want 1 3333 0", i, rsp_valid, rsp_data, cmd_ready);
         end
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%0b ready=%0b want 0 1", rsp_valid, cmd_ready); end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_pending_accept: got ready=%0b want 0", cmd_ready); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0777) begin errors++; $display("FAIL bp_pending_rsp: got valid=%0b data=%h want 1 0777", rsp_valid, rsp_data); end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_in_exec();
      logic [15:0] d, xa, xb;
      logic c, z;
      logic [3:0] xo;
      int lat;
      issue(LDI, 3'd1, 3'd0, 3'd0, 16'h0005, d, c, z, lat, xa, xb, xo);
      issue(LDI, 3'd2, 3'd0, 3'd0, 16'h0006, d, c, z, lat, xa, xb, xo);
      cmd_op = ADD; cmd_dst = 3'd6; cmd_srca = 3'd1; cmd_srcb = 3'd2; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      checks++; if (alu_a !== 16'h0005) begin errors++; $display("FAIL rexec_in_exec: got a=%h want 0005", alu_a); end
      rst_n = 1'b0;
      #1;
      checks++; if (alu_a !== 16'd0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rexec_abort: got a=%h ready=%0b want 0 1", alu_a, cmd_ready); end
      repeat (2) begin
         @(posedge clk); #1;
         checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rexec_no_rsp: got %0b want 0", rsp_valid); end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rexec_idle: got ready=%0b valid=%0b want 1 0", cmd_ready, rsp_valid); end
      issue(RD, 3'd0, 3'd6, 3'd0, 16'd0, d, c, z, lat, xa, xb, xo);
      checks++; if (d !== 16'h0000 || z !== 1'b1) begin errors++; $display("FAIL rexec_r6: got %h zero=%0b want 0000 zero=1", d, z); end
   endtask

   task automatic test_random();
      logic [15:0] d, xa, xb, ed, ea, eb, imm;
      logic c, z, ec, ez;
      logic [3:0] xo, eo, o;
      logic [2:0] dd, sa, sb;
      int lat;
      do_reset();
      for (int i = 0; i < 60; i++) begin
         o  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) o = LDI;
         dd = 3'($urandom_range(0, 7));
         sa = 3'($urandom_range(0, 7));
         sb = 3'($urandom_range(0, 7));
         imm = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
         issue(o, dd, sa, sb, imm, d, c, z, lat, xa, xb, xo);
         model_cmd(o, dd, sa, sb, imm, ed, ec, ez, ea, eb, eo);
         checks++;
         if (d !== ed || c !== ec || z !== ez) begin
            errors++;
            $display("FAIL rand_rsp_%0d op=%h: got %h/%0b/%0b want %h/%0b/%0b", i, o, d, c, z, ed, ec, ez);
         end
         checks++;
         if (xa !== ea || xb !== eb || xo !== eo) begin
            errors++;
            $display("FAIL rand_exec_%0d op=%h: got %h %h %h want %h %h %h", i, o, xa, xb, xo, ea, eb, eo);
         end
         checks++;
         if (flag_c !== m_fc || flag_z !== m_fz || lat !== 2) begin
            errors++;
            $display("FAIL rand_flags_%0d: got c=%0b z=%0b lat=%0d want %0b %0b 2", i, flag_c, flag_z, lat, m_fc, m_fz);
         end
      end
   endtask

   initial begin
      clk = 1'b0;
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_op = 4'd0; cmd_dst = 3'd0; cmd_srca = 3'd0; cmd_srcb = 3'd0; cmd_imm = 16'd0;
      rsp_ready = 1'b0;
      checks = 0;
      errors = 0;
      do_reset();
      test_reset();
      test_add_carry();
      test_sub_xor();
      test_shift_in_place();
      test_idle_hold();
      test_unimplemented_op();
      test_backpressure();
      test_reset_in_exec();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Command sequencer sitting directly upstream of the 16-bit combinational ALU. It accepts register-based commands over a valid/ready handshake and holds an 8-entry × 16-bit register file. It drives the ALU's A/B/OP inputs, captures RESULT/CARRY/ZERO, writes the result back, and returns each command's result over a response handshake. It also maintains architectural carry/zero flags for the last ALU operation.

## Interface
- DATA_W, 16, datapath width; must match the ALU.
- NREG, 8, register-file depth.
- REG_AW, 3, register address width; equals log2(NREG).

- CLK  in  1  single clock; all state updates on its rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  sequencer accepts a command; high only in IDLE.
- CMD_OP  in  4  opcode. 4'b0000–4'b1101 are passed to the ALU. 4'b1110 is READ. 4'b1111 is LOADI.
- CMD_DST  in  REG_AW  destination register.
- CMD_SRCA  in  REG_AW  source A; also the READ address.
- CMD_SRCB  in  REG_AW  source B.
- CMD_IMM  in  DATA_W  immediate for LOADI.
- A  out  DATA_W  ALU operand A.
- B  out  DATA_W  ALU operand B.
- OP  out  4  ALU opcode.
- RESULT  in  DATA_W  ALU result.
- CARRY  in  1  ALU carry.
- ZERO  in  1  ALU zero.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  consumer accepts the response.
- RSP_DATA  out  DATA_W  result, immediate, or read data.
- RSP_CARRY  out  1  carry of this command.
- RSP_ZERO  out  1  zero of this command.
- FLAG_C  out  1  carry of the last ALU-class command.
- FLAG_Z  out  1  zero of the last ALU-class command.

## Operation
- FSM states: IDLE, EXEC, RESP.
  - IDLE: CMD_READY=1. On CMD_VALID&&CMD_READY, latch OP/DST/SRCA/SRCB/IMM and go to EXEC.
  - EXEC: one cycle, then RESP.
  - RESP: RSP_VALID=1. On RSP_VALID&&RSP_READY, go to IDLE.
- ALU-class command (opcode 0000–1101):
  - In EXEC, A=reg[SRCA], B=reg[SRCB], OP=latched opcode.
  - At the end of EXEC, capture RESULT/CARRY/ZERO: reg[DST]<=RESULT; RSP_DATA<=RESULT; RSP_CARRY<=CARRY; RSP_ZERO<=ZERO; FLAG_C<=CARRY; FLAG_Z<=ZERO.
  - Opcodes the ALU does not implement are still forwarded. The ALU returns 0 for them, so reg[DST]<=0, carry 0, zero 1.
- LOADI: reg[DST]<=IMM; RSP_DATA=IMM; RSP_CARRY=0; RSP_ZERO=(IMM==0). FLAG_C/FLAG_Z unchanged.
- READ: RSP_DATA=reg[SRCA]; RSP_CARRY=0; RSP_ZERO=(reg[SRCA]==0). No register write. Flags unchanged.
- A/B/OP are driven only in EXEC with an ALU-class command. Otherwise A=0, B=0, OP=4'b0000.
- DST equal to SRCA or SRCB: sources read the pre-write value; write lands at the end of EXEC.
- Widths: all data is DATA_W wide. No sign extension. Register indices are used unmodified (NREG = 2^REG_AW, so no out-of-range addresses exist).

## Timing
- Reset (RST_N low, asynchronous):
  - state=IDLE; all registers 0; RSP_VALID=0; RSP_DATA=0; RSP_CARRY=0; RSP_ZERO=0; FLAG_C=0; FLAG_Z=0; A=B=0; OP=0.
  - CMD_READY=1 (IDLE), but no handshake is honoured while RST_N is low.
- Latency: command accepted at edge N; EXEC during cycle N+1; RSP_VALID high from cycle N+2.
- Throughput: at most one command per 3 cycles. CMD_READY=0 in EXEC and RESP, so there is no overlap.
- Backpressure: while RSP_VALID&&!RSP_READY, RSP_DATA/RSP_CARRY/RSP_ZERO are held stable and no new command is accepted.
- RSP_VALID drops in the cycle after the response handshake. CMD_READY rises in that same cycle.
- Reset mid-EXEC or mid-RESP: the in-flight command is discarded, no writeback, no response; all state returns to reset values.
- CMD_VALID deasserted in IDLE: the sequencer stays in IDLE and all outputs hold.

## Test plan
- Reset: assert RST_N low mid-stream → all outputs 0, CMD_READY=1. After release, READ r0..r7 each return 0x0000 with zero=1.
- Add with carry: LOADI r1=0xFFFF, LOADI r2=0x0001, ADD r3=r1+r2 → RSP_DATA 0x0000, RSP_CARRY=1, RSP_ZERO=1, FLAG_C=1, FLAG_Z=1. Then READ r3 → 0x0000, and FLAG_C/FLAG_Z are still 1.
- SUB/XOR: SUB r4=r2-r1 (0x0001-0xFFFF) → 0x0002, carry 0, zero 0. XOR r5=r1^r1 → 0x0000, zero 1. Each RSP_VALID appears exactly 2 cycles after acceptance.
- In-place shift: r1=0x8001, SHL r1=r1<<1 → RSP_DATA 0x0002; A=0x8001 and OP=4'b0101 during EXEC; a later READ r1 returns 0x0002.
- Backpressure: hold RSP_READY=0 for 5 cycles after an ADD → RSP_VALID stays high with stable data, CMD_READY=0, and a pending CMD_VALID is not accepted until 1 cycle after RSP_READY rises.
- Reset during EXEC of ADD r6=... → r6 stays 0, no RSP_VALID; FSM is in IDLE once RST_N releases.
